// File: rtl/elastic_reg_pipe.sv
// Elastic multi-stage register pipeline: valid/ready flow control, bubble collapse,
// synchronous flush and a registered occupancy count over async-reset data flops.
module elastic_reg_pipe #(
  parameter int               WIDTH          = 64,
  parameter int               DEPTH          = 3,
  parameter logic [WIDTH-1:0] RESET_VAL      = {WIDTH{1'b0}},
  parameter bit               FLUSH_CLR_DATA = 1'b0,
  localparam int              OW             = $clog2(DEPTH + 1)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [OW-1:0]    OCC
);

  // Handshake: a beat moves across a port on a rising CK edge where valid and
  // ready are both 1; valid never depends on ready, while ready is combinational
  // from the stage valids and OUT_READY so a full pipe still streams every cycle.

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    occ_nxt;

  // A stage can take a new entry when it is empty or its own entry moves on.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = ~v[DEPTH-1] | OUT_READY;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      rdy[k] = ~v[k] | rdy[k+1];
    end
  end

  assign IN_READY  = rdy[0] & ~FLUSH;
  assign OUT_VALID = v[DEPTH-1] & ~FLUSH;
  assign OUT_DATA  = d[DEPTH-1];
  assign OCC       = occ_q;

  always_comb begin
    src_v[0] = IN_VALID & IN_READY;
    src_d[0] = IN_DATA;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = v[k-1];
      src_d[k] = d[k-1];
    end
  end

  always_comb begin
    v_nxt = v;
    if (FLUSH) begin
      v_nxt = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) v_nxt[k] = src_v[k];
      end
    end
  end

  always_comb begin
    occ_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_nxt = occ_nxt + OW'(v_nxt[k]);
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      v     <= '0;
      occ_q <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VAL;
    end else begin
      v     <= v_nxt;
      occ_q <= occ_nxt;
      for (int k = 0; k < DEPTH; k++) begin
        if (FLUSH) begin
          if (FLUSH_CLR_DATA) d[k] <= RESET_VAL;
        end else if (rdy[k] && src_v[k]) begin
          // Data only toggles on real entries; bubbles leave the register untouched.
          d[k] <= src_d[k];
        end
      end
    end
  end

endmodule
